seq_mult_param: RTL

Parametrised sequential multiplier: WIDTH x WIDTH operands, one DIGIT x DIGIT partial product per clock, shifted and accumulated into a 2*WIDTH result.
Generalises the fixed 8x8/4x4 sequential multiplier. Adds operand width, digit size, a signed mode, abort, busy and a registered result.
Drives the same 3-bit state code to the seven-segment status decoder.

---
 rtl/seq_mult_pkg.sv | 26 ++
 rtl/seq_mult_param_mult_digit.sv | 14 +
 rtl/seq_mult_param.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/seq_mult_pkg.sv
// Shared definitions for the parametrised sequential multiplier.
//   state_e     : 3-bit state code, also driven to the seven-segment status decoder
//   calc_ndig   : digits per operand (WIDTH / DIGIT)
//   calc_npp    : partial products per operation (NDIG * NDIG)
//   params_ok   : legal WIDTH/DIGIT combination, checked at elaboration by the top
package seq_mult_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CALC = 3'd1,
        ST_FIX  = 3'd2
    } state_e;

    function automatic int calc_ndig(input int width, input int digit);
        return width / digit;
    endfunction

    function automatic int calc_npp(input int width, input int digit);
        return (width / digit) * (width / digit);
    endfunction

    function automatic bit params_ok(input int width, input int digit);
        return (digit >= 2) && (width >= digit) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/seq_mult_param_mult_digit.sv
// Combinational DIGIT x DIGIT unsigned multiplier.
//   a, b : DIGIT-bit unsigned digits
//   p    : 2*DIGIT-bit product (cannot overflow)
module mult_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0]   a,
    input  logic [DIGIT-1:0]   b,
    output logic [2*DIGIT-1:0] p
);

    assign p = {{DIGIT{1'b0}}, a} * {{DIGIT{1'b0}}, b};

endmodule

// File: rtl/seq_mult_param.sv
// Parametrised sequential multiplier. Operands are captured as magnitudes, one
// DIGIT x DIGIT partial product is shifted and accumulated per clock, and the
// sign is applied once in the FIX state before the result is registered.
//   clk            : rising-edge clock
//   reset_a        : asynchronous active-low reset
//   dataa, datab   : WIDTH-bit operands, sampled on the accepting edge
//   start          : request, accepted only in IDLE (and only without abort)
//   signed_mode    : two's-complement operands (honoured when SIGNED_EN=1)
//   abort          : cancel an operation in CALC or FIX; no result, no done
//   busy           : high from the accepting edge until the result edge
//   done_flag      : one-cycle pulse, product8x8_out valid from this cycle
//   product8x8_out : 2*WIDTH registered result, held until the next done
//   state_out      : IDLE=0, CALC=1, FIX=2
// Handshake: start is a level request; an edge with state==IDLE, start=1 and
// abort=0 accepts it, otherwise it is dropped (no queuing). done_flag is the
// only completion indication and is never stalled by the consumer.
module seq_mult_param
    import seq_mult_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DIGIT     = 4,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_a,
    input  logic [WIDTH-1:0]     dataa,
    input  logic [WIDTH-1:0]     datab,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done_flag,
    output logic [2*WIDTH-1:0]   product8x8_out,
    output logic [2:0]           state_out
);

    localparam int NDIG = calc_ndig(WIDTH, DIGIT);
    localparam int NPP  = calc_npp(WIDTH, DIGIT);
    localparam int CW   = (NPP > 1) ? $clog2(NPP) : 1;
    localparam int PW   = 2 * WIDTH;
    localparam logic [CW-1:0] K_LAST = CW'(NPP - 1);

    if (!params_ok(WIDTH, DIGIT)) begin : g_bad_params
        $error("seq_mult_param: WIDTH must be a multiple of DIGIT and DIGIT >= 2");
    end

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [PW-1:0]      acc_q, acc_d;
    logic [CW-1:0]      k_q, k_d;
    logic               neg_q, neg_d;
    logic [PW-1:0]      prod_q, prod_d;
    logic               done_q, done_d;

    logic               signed_eff;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    int                 i_idx, j_idx;
    logic [DIGIT-1:0]   a_dig, b_dig;
    logic [2*DIGIT-1:0] pp;
    logic [PW-1:0]      pp_ext;
    logic [PW-1:0]      acc_sum;
    logic [PW-1:0]      result;

    // Magnitude capture: 0 - x in WIDTH bits maps -2^(WIDTH-1) onto the
    // unsigned value 2^(WIDTH-1), which is exactly the magnitude wanted.
    always_comb begin
        signed_eff = signed_mode & SIGNED_EN;
        a_neg      = signed_eff & dataa[WIDTH-1];
        b_neg      = signed_eff & datab[WIDTH-1];
        a_mag      = a_neg ? (WIDTH'(0) - dataa) : dataa;
        b_mag      = b_neg ? (WIDTH'(0) - datab) : datab;
    end

    // Digit select: k walks i (multiplicand digit) slowly, j (multiplier digit) fast.
    always_comb begin
        i_idx = int'(k_q) / NDIG;
        j_idx = int'(k_q) % NDIG;
        a_dig = '0;
        b_dig = '0;
        for (int n = 0; n < NDIG; n++) begin
            if (n == i_idx) a_dig = a_q[n*DIGIT +: DIGIT];
            if (n == j_idx) b_dig = b_q[n*DIGIT +: DIGIT];
        end
    end

    mult_digit #(
        .DIGIT (DIGIT)
    ) u_mult_digit (
        .a (a_dig),
        .b (b_dig),
        .p (pp)
    );

    always_comb begin
        pp_ext  = PW'(pp) << (DIGIT * (i_idx + j_idx));
        acc_sum = acc_q + pp_ext;
        result  = neg_q ? (PW'(0) - acc_q) : acc_q;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        k_d     = k_q;
        neg_d   = neg_q;
        prod_d  = prod_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // abort has priority over a simultaneous start
                if (start && !abort) begin
                    a_d     = a_mag;
                    b_d     = b_mag;
                    neg_d   = a_neg ^ b_neg;
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = acc_sum;
                    k_d   = k_q + CW'(1);
                    if (k_q == K_LAST) state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    prod_d  = result;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            k_q     <= '0;
            neg_q   <= 1'b0;
            prod_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
            neg_q   <= neg_d;
            prod_q  <= prod_d;
            done_q  <= done_d;
        end
    end

    assign busy           = (state_q != ST_IDLE);
    assign done_flag      = done_q;
    assign product8x8_out = prod_q;
    assign state_out      = state_q;

endmodule
